// File: rtl/alu_xor_wb_driver_if.sv
// Wishbone slave bus bundle for alu_xor_wb_driver; the CPU/bench side uses the master modport.
interface alu_xor_wb_driver_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i,
        output wbs_cyc_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_dat_i,
        output wbs_adr_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i,
        input  wbs_cyc_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_dat_i,
        input  wbs_adr_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/alu_xor_wb_driver.sv
// Wishbone-slave stimulus driver and result checker for the dual 4-bit ALU comparator.
// Optional macro ALU_DRV_IRQ_EN adds irq_o and the STATUS IRQ_EN bit.
module alu_xor_wb_driver #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SWEEP_BITS    = 20
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    alu_xor_wb_driver_if.slave       wbs,
    output logic [3:0]               a0,
    output logic [3:0]               b0,
    output logic [3:0]               a1,
    output logic [3:0]               b1,
    output logic [1:0]               alu_sel1,
    output logic [1:0]               alu_sel2,
    input  logic [3:0]               alu_out1,
    input  logic [3:0]               alu_out2,
    input  logic                     carry_out1,
    input  logic                     carry_out2,
    input  logic [3:0]               x,
    input  logic                     y,
    output logic                     busy_o
`ifdef ALU_DRV_IRQ_EN
    ,
    output logic                     irq_o
`endif
);

    localparam logic [2:0]  OffCtrl     = 3'd0;
    localparam logic [2:0]  OffOperand  = 3'd1;
    localparam logic [2:0]  OffResult   = 3'd2;
    localparam logic [2:0]  OffStatus   = 3'd3;
    localparam logic [2:0]  OffSweepIdx = 3'd4;
    localparam logic [3:0]  SettleLoad  = 4'(SETTLE_CYCLES - 1);
    localparam logic [19:0] SweepLast   = 20'((32'd1 << SWEEP_BITS) - 32'd1);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWait,
        StCapture,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_start;
    logic        r_mode;
    logic [19:0] r_operand;
    logic [19:0] r_drv;
    logic [19:0] r_idx;
    logic [3:0]  r_settle;
    logic [14:0] r_result;
    logic [15:0] r_count;
    logic        r_done;
    logic        r_busy;
    logic        w_irq_en_bit;

    logic        w_hit;
    logic        w_mapped;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_idle;
    logic        w_wr_ctrl;
    logic        w_start_req;
    logic        w_clr_cnt;
    logic        w_wr_oper;
    logic        w_wr_stat;
    logic        w_done_w1c;
    logic        w_run_start;
    logic        w_capture;
    logic        w_sweep_step;
    logic        w_mismatch;
    logic [31:0] w_rdata;
    logic        w_unused;

    // ---------------------------------------------------------------------------------------
    // Bus decode. The ack cycle masks a new hit so a held strobe produces exactly one ack.
    // ---------------------------------------------------------------------------------------
    assign w_hit = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack &
                   (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off       = wbs.wbs_adr_i[4:2];
    assign w_mapped    = (wbs.wbs_adr_i[7:5] == 3'd0) && (w_off <= OffSweepIdx);
    assign w_wr        = w_hit & wbs.wbs_we_i & w_mapped;
    assign w_idle      = (r_state == StIdle);

    assign w_wr_ctrl   = w_wr & (w_off == OffCtrl) & wbs.wbs_sel_i[0];
    assign w_start_req = w_wr_ctrl & wbs.wbs_dat_i[0] & w_idle;
    assign w_clr_cnt   = w_wr_ctrl & wbs.wbs_dat_i[2];
    assign w_wr_oper   = w_wr & (w_off == OffOperand) & w_idle;
    assign w_wr_stat   = w_wr & (w_off == OffStatus) & wbs.wbs_sel_i[0];
    assign w_done_w1c  = w_wr_stat & wbs.wbs_dat_i[1];

    assign w_unused = ^{wbs.wbs_sel_i[3], wbs.wbs_dat_i[31:20], wbs.wbs_adr_i[1:0]};

`ifdef ALU_DRV_IRQ_EN
    logic r_irq_en;
    assign w_irq_en_bit = r_irq_en;
    assign irq_o        = r_done & r_irq_en;
`else
    assign w_irq_en_bit = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'd0;
        if (w_mapped) begin
            case (w_off)
                OffOperand:  w_rdata = {12'd0, r_operand};
                OffResult:   w_rdata = {17'd0, r_result};
                OffStatus:   w_rdata = {r_count, 13'd0, w_irq_en_bit, r_done, r_busy};
                OffSweepIdx: w_rdata = {12'd0, r_idx};
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
            r_start <= 1'b0;
        end else begin
            r_ack   <= w_hit;
            r_rdata <= (w_hit & ~wbs.wbs_we_i) ? w_rdata : 32'd0;
            r_start <= w_start_req;
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_rdata;

    // ---------------------------------------------------------------------------------------
    // Configuration registers; MODE and OPERAND are frozen while a run is in progress.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mode    <= 1'b0;
            r_operand <= 20'd0;
        end else begin
            if (w_wr_ctrl && w_idle) begin
                r_mode <= wbs.wbs_dat_i[1];
            end
            if (w_wr_oper) begin
                if (wbs.wbs_sel_i[0]) r_operand[7:0]   <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) r_operand[15:8]  <= wbs.wbs_dat_i[15:8];
                if (wbs.wbs_sel_i[2]) r_operand[19:16] <= wbs.wbs_dat_i[19:16];
            end
        end
    end

`ifdef ALU_DRV_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
        end else if (w_wr_stat) begin
            r_irq_en <= wbs.wbs_dat_i[2];
        end
    end
`endif

    // ---------------------------------------------------------------------------------------
    // Run FSM
    // ---------------------------------------------------------------------------------------
    assign w_run_start  = w_idle & r_start;
    assign w_capture    = (r_state == StCapture);
    assign w_sweep_step = w_capture & r_mode & (r_idx != SweepLast);
    assign w_mismatch   = (x != 4'd0) | y;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_start) w_state_d = StApply;
            end
            StApply: begin
                w_state_d = StWait;
            end
            StWait: begin
                if (r_settle == 4'd0) w_state_d = StCapture;
            end
            StCapture: begin
                w_state_d = w_sweep_step ? StApply : StDone;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Vector drive, settle timer and result capture
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_drv    <= 20'd0;
            r_idx    <= 20'd0;
            r_settle <= 4'd0;
            r_result <= 15'd0;
        end else begin
            if (w_run_start) begin
                r_drv <= r_mode ? 20'd0 : r_operand;
                if (r_mode) r_idx <= 20'd0;
            end else if (w_sweep_step) begin
                r_drv <= r_idx + 20'd1;
                r_idx <= r_idx + 20'd1;
            end

            if (r_state == StApply) begin
                r_settle <= SettleLoad;
            end else if ((r_state == StWait) && (r_settle != 4'd0)) begin
                r_settle <= r_settle - 4'd1;
            end

            if (w_capture) begin
                r_result <= {y, x, carry_out2, carry_out1, alu_out2, alu_out1};
            end
        end
    end

    // Status: a clear request beats a same-cycle increment; DONE beats a same-cycle W1C.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_count <= 16'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_clr_cnt) begin
                r_count <= 16'd0;
            end else if (w_capture && r_mode && w_mismatch && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end

            if (r_state == StDone) begin
                r_done <= 1'b1;
            end else if (w_run_start || w_done_w1c) begin
                r_done <= 1'b0;
            end

            if (w_run_start) begin
                r_busy <= 1'b1;
            end else if (r_state == StDone) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign {alu_sel2, alu_sel1, b1, a1, b0, a0} = r_drv;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_alu_xor_wb_driver.sv
// Directed + randomized bench for alu_xor_wb_driver with a behavioural stand-in for the ALU pair.
// Compile with ALU_DRV_IRQ_EN defined to also exercise irq_o.
module tb_alu_xor_wb_driver;

    localparam int unsigned  Settle    = 2;
    localparam int unsigned  SweepBits = 4;
    localparam logic [31:0]  Base      = 32'h3000_0000;
    localparam logic [31:0]  AdrCtrl   = Base + 32'h00;
    localparam logic [31:0]  AdrOper   = Base + 32'h04;
    localparam logic [31:0]  AdrResult = Base + 32'h08;
    localparam logic [31:0]  AdrStatus = Base + 32'h0C;
    localparam logic [31:0]  AdrIdx    = Base + 32'h10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_xor_wb_driver_if u_bus ();

    logic [3:0] a0, b0, a1, b1, out1, out2, x;
    logic [1:0] sel1, sel2;
    logic       c1, c2, y, busy;
`ifdef ALU_DRV_IRQ_EN
    logic       irq;
`endif

    alu_xor_wb_driver #(
        .BASE_ADDR     (Base),
        .SETTLE_CYCLES (Settle),
        .SWEEP_BITS    (SweepBits)
    ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (u_bus.slave),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .alu_sel1   (sel1),
        .alu_sel2   (sel2),
        .alu_out1   (out1),
        .alu_out2   (out2),
        .carry_out1 (c1),
        .carry_out2 (c2),
        .x          (x),
        .y          (y),
        .busy_o     (busy)
`ifdef ALU_DRV_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

    // Behavioural ALU: add, subtract (carry = borrow), and, xor.
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
        int ai = int'(a);
        int bi = int'(b);
        int r;
        case (s)
            2'd0:    r = ai + bi;
            2'd1:    r = (ai - bi) & 32'h1F;
            2'd2:    r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        return 5'(r);
    endfunction

    // Stand-in for the compared ALU pair; equal_mode forces matching ALUs plus injected faults.
    logic        equal_mode;
    logic [15:0] fault_mask;
    always_comb begin
        {c1, out1} = alu_ref(a0, b0, sel1);
        {c2, out2} = alu_ref(a1, b1, sel2);
        if (equal_mode) begin
            x = fault_mask[a0] ? 4'h1 : 4'h0;
            y = 1'b0;
        end else begin
            x = out1 ^ out2;
            y = c1 ^ c2;
        end
    end

    function automatic logic [31:0] exp_result(input logic [19:0] op);
        logic [4:0] r1, r2;
        r1 = alu_ref(op[3:0], op[7:4], op[17:16]);
        r2 = alu_ref(op[11:8], op[15:12], op[19:18]);
        return {17'd0, r1[4] ^ r2[4], r1[3:0] ^ r2[3:0], r2[4], r1[4], r2[3:0], r1[3:0]};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int busy_total = 0;

    always @(negedge clk) if (busy) busy_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        @(negedge clk);
        u_bus.wbs_stb_i = 1'b1;
        u_bus.wbs_cyc_i = 1'b1;
        u_bus.wbs_we_i  = we;
        u_bus.wbs_adr_i = adr;
        u_bus.wbs_dat_i = dat;
        u_bus.wbs_sel_i = sel;
        acked = 1'b0;
        rdat  = 32'd0;
        for (int i = 0; i < 6 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (u_bus.wbs_ack_o) begin
                acked = 1'b1;
                rdat  = u_bus.wbs_dat_o;
            end
        end
        u_bus.wbs_stb_i = 1'b0;
        u_bus.wbs_cyc_i = 1'b0;
        u_bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        logic [31:0] d;
        logic        ack;
        wb_xfer(adr, 1'b1, dat, sel, d, ack);
        check("write_ack", 32'(ack), 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        logic ack;
        wb_xfer(adr, 1'b0, 32'd0, 4'hF, dat, ack);
        check("read_ack", 32'(ack), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        ack;
        logic [19:0] op;
        int          b0_snap;
        int          exp_cnt;

        rst = 1'b1;
        equal_mode = 1'b0;
        fault_mask = 16'd0;
        u_bus.wbs_stb_i = 1'b0;
        u_bus.wbs_cyc_i = 1'b0;
        u_bus.wbs_we_i  = 1'b0;
        u_bus.wbs_sel_i = 4'h0;
        u_bus.wbs_dat_i = 32'd0;
        u_bus.wbs_adr_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(u_bus.wbs_ack_o), 32'd0);
        check("rst_dat", u_bus.wbs_dat_o, 32'd0);
        check("rst_drv", 32'({sel2, sel1, b1, a1, b0, a0}), 32'd0);
        wb_read(AdrStatus, rd); check("rst_status", rd, 32'd0);
        wb_read(AdrOper, rd);   check("rst_operand", rd, 32'd0);
        wb_read(AdrIdx, rd);    check("rst_idx", rd, 32'd0);
`ifdef ALU_DRV_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif

        // Bus rules
        wb_xfer(Base + 32'h100, 1'b0, 32'd0, 4'hF, rd, ack);
        check("outside_no_ack", 32'(ack), 32'd0);
        wb_read(Base + 32'h18, rd); check("unmapped_rd", rd, 32'd0);
        wb_write(Base + 32'h18, 32'hFFFF_FFFF, 4'hF);
        wb_read(AdrCtrl, rd);       check("ctrl_reads0", rd, 32'd0);

        // Directed single run
        wb_write(AdrOper, 32'h0001_5A3C, 4'hF);
        wb_read(AdrOper, rd); check("operand_rb", rd, 32'h0001_5A3C);
        check("drv_before_start", 32'({sel2, sel1, b1, a1, b0, a0}), 32'd0);
        b0_snap = busy_total;
        wb_write(AdrCtrl, 32'h1, 4'hF);
        check("busy_in_ack_cycle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("busy_rises", 32'(busy), 32'd1);
        check("single_drv", 32'({sel2, sel1, b1, a1, b0, a0}), 32'h1_5A3C);
        wait_idle();
        check("single_busy_len", 32'(busy_total - b0_snap), 32'(Settle + 3));
        wb_read(AdrResult, rd); check("single_result", rd, exp_result(20'h1_5A3C));
        wb_read(AdrStatus, rd); check("single_status", rd, 32'h2);
        wb_write(AdrStatus, 32'h2, 4'h1);
        wb_read(AdrStatus, rd); check("done_w1c", rd, 32'h0);

        // Byte-lane write
        wb_write(AdrOper, 32'hFFFF_FFFF, 4'b0001);
        wb_read(AdrOper, rd); check("byte_write", rd, 32'h0001_5AFF);

        // Randomized single runs against the reference model
        for (int k = 0; k < 5; k++) begin
            op = 20'($urandom_range(0, 32'h000F_FFFF));
            wb_write(AdrOper, {12'd0, op}, 4'hF);
            wb_write(AdrCtrl, 32'h1, 4'h1);
            wait_idle();
            check("rand_drv", 32'({sel2, sel1, b1, a1, b0, a0}), {12'd0, op});
            wb_read(AdrResult, rd); check("rand_result", rd, exp_result(op));
            wb_read(AdrStatus, rd); check("rand_status", rd, 32'h2);
        end

        // Sweep with matching ALUs; START/OPERAND/MODE writes while busy are ignored
        equal_mode = 1'b1;
        fault_mask = 16'd0;
        wb_write(AdrOper, 32'h0000_1111, 4'hF);
        b0_snap = busy_total;
        wb_write(AdrCtrl, 32'h3, 4'h1);
        wb_write(AdrCtrl, 32'h1, 4'h1);
        wb_write(AdrOper, 32'h0001_2345, 4'hF);
        wait_idle();
        check("sweep_busy_len", 32'(busy_total - b0_snap), 32'((1 << SweepBits) * (Settle + 2) + 1));
        wb_read(AdrIdx, rd);    check("sweep_idx_end", rd, 32'((1 << SweepBits) - 1));
        wb_read(AdrStatus, rd); check("sweep_status", rd, 32'h2);
        wb_read(AdrOper, rd);   check("oper_wr_ignored", rd, 32'h0000_1111);
        check("sweep_hold_drv", 32'({sel2, sel1, b1, a1, b0, a0}), 32'((1 << SweepBits) - 1));

        // Sweep with injected faults
        fault_mask = 16'h0220;
        exp_cnt = 0;
        for (int v = 0; v < (1 << SweepBits); v++) if (fault_mask[v]) exp_cnt++;
        wb_write(AdrCtrl, 32'h3, 4'h1);
        wait_idle();
        wb_read(AdrStatus, rd); check("fault_count", rd, {16'(exp_cnt), 16'h2});
        wb_write(AdrCtrl, 32'h4, 4'h1);
        wb_read(AdrStatus, rd); check("clr_count", rd, 32'h2);

        // CLR_CNT lands on the edge that captures vector 5 (the only faulty one)
        fault_mask = 16'h0020;
        wb_write(AdrCtrl, 32'h3, 4'h1);
        repeat (24) @(posedge clk);
        wb_write(AdrCtrl, 32'h4, 4'h1);
        wait_idle();
        wb_read(AdrStatus, rd); check("clr_beats_inc", rd, 32'h2);

`ifdef ALU_DRV_IRQ_EN
        wb_write(AdrStatus, 32'h6, 4'h1);
        check("irq_low_after_w1c", 32'(irq), 32'd0);
`endif

        // Done W1C lands on the edge leaving DONE of a single run
        wb_write(AdrCtrl, 32'h1, 4'h1);
        repeat (5) @(posedge clk);
        wb_write(AdrStatus, 32'h2, 4'h1);
        wait_idle();
`ifdef ALU_DRV_IRQ_EN
        wb_read(AdrStatus, rd); check("done_set_wins", rd, 32'h6);
        check("irq_with_done", 32'(irq), 32'd1);
        wb_write(AdrStatus, 32'h2, 4'h1);
        check("irq_cleared", 32'(irq), 32'd0);
        wb_write(AdrCtrl, 32'h1, 4'h1);
        wait_idle();
        check("irq_disabled", 32'(irq), 32'd0);
        wb_read(AdrStatus, rd); check("status_no_irq_en", rd, 32'h2);
`else
        wb_read(AdrStatus, rd); check("done_set_wins", rd, 32'h2);
`endif

        // Reset in the middle of a sweep (inside WAIT of vector 2), with a bus access pending
        fault_mask = 16'hFFFF;
        wb_write(AdrCtrl, 32'h3, 4'h1);
        repeat (11) @(posedge clk);
        #1;
        check("mid_sweep_vec", 32'(a0), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        u_bus.wbs_stb_i = 1'b1;
        u_bus.wbs_cyc_i = 1'b1;
        u_bus.wbs_we_i  = 1'b0;
        u_bus.wbs_adr_i = AdrStatus;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_drv", 32'({sel2, sel1, b1, a1, b0, a0}), 32'd0);
        check("abort_no_ack", 32'(u_bus.wbs_ack_o), 32'd0);
        rst = 1'b0;
        u_bus.wbs_stb_i = 1'b0;
        u_bus.wbs_cyc_i = 1'b0;
        wb_read(AdrStatus, rd); check("abort_status", rd, 32'd0);
        wb_read(AdrIdx, rd);    check("abort_idx", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
